// File: rtl/write_back_regfile.sv
// ----------------------------------------------------------------------------
// write_back_regfile
//
// Write-back stage of a five-stage RISC pipeline merged with the architectural
// register file. The write-back value is picked from the ALU result, the load
// data or the link address (jal). It is written into the register file on the
// rising clock edge and is also exported for forwarding.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN - when defined, a read port addressing the register that
//                       is being written in the same cycle returns the value
//                       being written (write-through). When undefined, reads
//                       always return the stored contents.
//
// Parameters:
//   DATA_WIDTH    - width of register contents, write-back data and read data
//   ADDRESS_WIDTH - width of the link address i_PCPlus4W
//   RF_ADDR_WIDTH - register address width; depth = 2**RF_ADDR_WIDTH
//
// Ports:
//   i_CLK        - clock; register-file writes on the rising edge
//   i_RST        - asynchronous, active-low reset; clears every entry
//   i_ALUOutW    - ALU result from the MEM/WB register
//   i_ReadDataW  - load data from the MEM/WB register
//   i_PCPlus4W   - link address for jal
//   i_WriteRegW  - destination register
//   i_RegWriteW  - write enable
//   i_MemtoRegW  - result select (00 ALU, 01 load, 10 link, 11 ALU)
//   i_A1, i_A2   - decode-stage read addresses
//   o_RD1, o_RD2 - asynchronous read data for i_A1 and i_A2
//   o_ResultW    - selected write-back value, also used for forwarding
// ----------------------------------------------------------------------------
module write_back_regfile #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [DATA_WIDTH-1:0]    i_ALUOutW,
    input  logic [DATA_WIDTH-1:0]    i_ReadDataW,
    input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4W,
    input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
    input  logic                     i_RegWriteW,
    input  logic [1:0]               i_MemtoRegW,
    input  logic [RF_ADDR_WIDTH-1:0] i_A1,
    input  logic [RF_ADDR_WIDTH-1:0] i_A2,
    output logic [DATA_WIDTH-1:0]    o_RD1,
    output logic [DATA_WIDTH-1:0]    o_RD2,
    output logic [DATA_WIDTH-1:0]    o_ResultW
);

    localparam int DEPTH = 2 ** RF_ADDR_WIDTH;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_LINK = 2'b10,
        SEL_ALU2 = 2'b11
    } result_sel_e;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DATA_WIDTH-1:0] w_link;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_write;

    // Link address fitted to the data width: zero-extended when narrower,
    // truncated when wider.
    generate
        if (ADDRESS_WIDTH >= DATA_WIDTH) begin : g_link_trunc
            assign w_link = i_PCPlus4W[DATA_WIDTH-1:0];
        end else begin : g_link_zext
            assign w_link = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, i_PCPlus4W};
        end
    endgenerate

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path through the block can leave it unassigned (no latch).
    always_comb begin
        w_result = i_ALUOutW;
        unique case (result_sel_e'(i_MemtoRegW))
            SEL_ALU  : w_result = i_ALUOutW;
            SEL_LOAD : w_result = i_ReadDataW;
            SEL_LINK : w_result = w_link;
            SEL_ALU2 : w_result = i_ALUOutW;
            default  : w_result = i_ALUOutW;
        endcase
    end

    assign o_ResultW = w_result;

    // Register 0 is hard-wired to zero, so a write addressed to it is dropped.
    assign w_write = i_RegWriteW && (i_WriteRegW != '0);

    // NOTE: this storage is deliberately reset (it is architectural state that
    // must read zero after reset), which keeps it in flops rather than RAM.
    // Sequential state is updated with non-blocking assignments only.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write) begin
            r_regs[i_WriteRegW] <= w_result;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    // Write-through: a read of the register being written this cycle sees
    // the incoming value instead of the old contents.
    assign w_hit1 = w_write && (i_A1 == i_WriteRegW);
    assign w_hit2 = w_write && (i_A2 == i_WriteRegW);

    always_comb begin
        o_RD1 = r_regs[i_A1];
        o_RD2 = r_regs[i_A2];
        if (!i_RST) begin
            o_RD1 = '0;
            o_RD2 = '0;
        end else begin
            if (w_hit1) o_RD1 = w_result;
            if (w_hit2) o_RD2 = w_result;
        end
    end
`else
    // Plain asynchronous reads of stored contents; the explicit gate keeps
    // the outputs at zero for the whole time reset is held.
    always_comb begin
        o_RD1 = r_regs[i_A1];
        o_RD2 = r_regs[i_A2];
        if (!i_RST) begin
            o_RD1 = '0;
            o_RD2 = '0;
        end
    end
`endif

endmodule

// File: tb/tb_write_back_regfile.sv
// ----------------------------------------------------------------------------
// tb_write_back_regfile
//
// Self-checking bench for write_back_regfile (default parameters). A
// behavioural model (an array of 32 words plus the result-select rule) gives
// every expected value. Inputs change on the falling edge. Outputs are checked
// while the clock is low, away from the rising edge that writes the file.
// Honours REGFILE_BYPASS_EN the same way as the design.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_write_back_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic        we;
    logic [1:0]  mtr;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] result;

    int vectors;
    int miscompares;

    logic [31:0] model [32];

    write_back_regfile #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .RF_ADDR_WIDTH(5)
    ) dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_ALUOutW  (alu),
        .i_ReadDataW(rdata),
        .i_PCPlus4W (pc),
        .i_WriteRegW(wreg),
        .i_RegWriteW(we),
        .i_MemtoRegW(mtr),
        .i_A1       (a1),
        .i_A2       (a2),
        .o_RD1      (rd1),
        .o_RD2      (rd2),
        .o_ResultW  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_result();
        if (mtr == 2'b01) return rdata;
        if (mtr == 2'b10) return pc;
        return alu;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!rst) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && wreg != 5'd0 && a == wreg) return exp_result();
`endif
        return model[a];
    endfunction

    // One full clock: the model commits at the rising edge, then control
    // returns on the next falling edge with inputs still unchanged.
    task automatic step();
        @(posedge clk);
        if (rst && we && wreg != 5'd0) model[wreg] = exp_result();
        @(negedge clk);
    endtask

    task automatic drive_write(input logic [4:0] r, input logic [31:0] v);
        we = 1'b1; wreg = r; mtr = 2'b00; alu = v;
        step();
        we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        we = 1'b1; wreg = 5'd4; mtr = 2'b00; alu = 32'h0BAD_F00D;
        a1 = 5'd4; a2 = 5'd31;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        step();  // reset has priority over this write
        #1;
        vectors++;
        if (rd1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd1 got %h want %h", rd1, 32'h0);
        end
        vectors++;
        if (rd2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd2 got %h want %h", rd2, 32'h0);
        end
        vectors++;
        if (result !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL reset_result_comb got %h want %h", result, 32'h0BAD_F00D);
        end
        we = 1'b0;
        rst = 1'b1;
        // first rising edge after release must accept a write
        drive_write(5'd4, 32'h1357_9BDF);
        a1 = 5'd4; #1;
        vectors++;
        if (rd1 !== 32'h1357_9BDF) begin
            miscompares++;
            $display("FAIL first_write_after_reset got %h want %h", rd1, 32'h1357_9BDF);
        end
    endtask

    task automatic test_async_clear();
        for (int n = 1; n < 32; n++) drive_write(5'(n), 32'hA5A5_0000 + n);
        a1 = 5'd7; a2 = 5'd31; #1;
        vectors++;
        if (rd1 !== 32'hA5A5_0007 || rd2 !== 32'hA5A5_001F) begin
            miscompares++;
            $display("FAIL fill_check got %h/%h want %h/%h", rd1, rd2, 32'hA5A5_0007, 32'hA5A5_001F);
        end
        // assert reset while clk is low: contents must vanish with no edge
        we = 1'b1; wreg = 5'd5; alu = 32'h7777_7777;
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int n = 0; n < 32; n++) begin
            a1 = 5'(n); a2 = 5'(31 - n); #0.1;
            vectors++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                miscompares++;
                $display("FAIL async_clear a=%0d got %h/%h want 0/0", n, rd1, rd2);
            end
        end
        we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_result_mux();
        alu = 32'h1111_2222; rdata = 32'hDEAD_BEEF; pc = 32'h0000_4004;
        for (int s = 0; s < 4; s++) begin
            mtr = 2'(s); #1;
            vectors++;
            if (result !== exp_result()) begin
                miscompares++;
                $display("FAIL result_mux sel=%0d got %h want %h", s, result, exp_result());
            end
        end
        // load write-back into x8
        we = 1'b1; wreg = 5'd8; mtr = 2'b01; a1 = 5'd8;
        step();
        we = 1'b0; #1;
        vectors++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL load_writeback got %h want %h", rd1, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_zero_write();
        drive_write(5'd0, 32'h1234_5678);
        a1 = 5'd0; #1;
        vectors++;
        if (rd1 !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_write got %h want %h", rd1, 32'h0);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] want_before;
`ifdef REGFILE_BYPASS_EN
        want_before = 32'h2;
`else
        want_before = 32'h1;
`endif
        drive_write(5'd9, 32'h1);
        we = 1'b1; wreg = 5'd9; mtr = 2'b00; alu = 32'h2; a2 = 5'd9; #1;
        vectors++;
        if (rd2 !== want_before || rd2 !== exp_read(5'd9)) begin
            miscompares++;
            $display("FAIL same_cycle_before got %h want %h", rd2, want_before);
        end
        step();
        we = 1'b0; #1;
        vectors++;
        if (rd2 !== 32'h2) begin
            miscompares++;
            $display("FAIL same_cycle_after got %h want %h", rd2, 32'h2);
        end
    endtask

    task automatic test_hold();
        drive_write(5'd3, 32'h0000_0333);
        we = 1'b0; wreg = 5'd3; mtr = 2'b00; alu = 32'hFFFF_FFFF; a1 = 5'd3;
        step(); #1;
        vectors++;
        if (rd1 !== 32'h0000_0333) begin
            miscompares++;
            $display("FAIL hold_no_we got %h want %h", rd1, 32'h0000_0333);
        end
    endtask

    task automatic test_dual_port();
        drive_write(5'd17, 32'h55);
        a1 = 5'd17; a2 = 5'd17; #1;
        vectors++;
        if (rd1 !== 32'h55 || rd2 !== 32'h55) begin
            miscompares++;
            $display("FAIL dual_same_addr got %h/%h want %h/%h", rd1, rd2, 32'h55, 32'h55);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            we    = ($urandom_range(0, 3) != 0);
            wreg  = 5'($urandom_range(0, 31));
            mtr   = 2'($urandom_range(0, 3));
            alu   = $urandom;
            rdata = $urandom;
            pc    = $urandom;
            a1    = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
            a2    = 5'($urandom_range(0, 31));
            #1;
            vectors++;
            if (result !== exp_result() || rd1 !== exp_read(a1) || rd2 !== exp_read(a2)) begin
                miscompares++;
                $display("FAIL random k=%0d got res=%h rd1=%h rd2=%h want %h %h %h",
                         k, result, rd1, rd2, exp_result(), exp_read(a1), exp_read(a2));
            end
            step();
        end
        we = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b0; we = 1'b0; wreg = '0; mtr = '0;
        alu = '0; rdata = '0; pc = '0; a1 = '0; a2 = '0;
        @(negedge clk);
        test_reset();
        test_async_clear();
        test_result_mux();
        test_zero_write();
        test_same_cycle();
        test_hold();
        test_dual_port();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
